// File: rtl/btn_pkg.sv
// Shared definitions for the button debouncer: per-channel FSM state encoding
// and the default timing constants used by btn_debounce.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam int DEFAULT_NUM_BTN       = 3;
    localparam int DEFAULT_DEBOUNCE_CYC  = 200000;
    localparam int DEFAULT_REPEAT_DELAY  = 50000000;
    localparam int DEFAULT_REPEAT_PERIOD = 10000000;

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for one raw button level into the clk domain.
// Both flops clear on the asynchronous reset so a held button re-qualifies
// from scratch once reset is released.
module btn_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Next values of the synchronizer chain: raw input, then first stage.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel button debouncer with one-cycle press pulses.
// Each channel: 2-flop synchronizer, then a 4-state FSM that requires
// DEBOUNCE_CYC consecutive stable samples to accept a press or a release.
// Optional feature macro: BTN_AUTOREPEAT_EN adds hold-to-repeat pulses
// (first after REPEAT_DELAY cycles in PRESSED, then every REPEAT_PERIOD).
module btn_debounce
    import btn_pkg::*;
#(
    parameter int NUM_BTN       = DEFAULT_NUM_BTN,
    parameter int DEBOUNCE_CYC  = DEFAULT_DEBOUNCE_CYC,
    parameter int REPEAT_DELAY  = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEFAULT_REPEAT_PERIOD
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

`ifdef BTN_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RPT_ONE         = RPT_W'(1);
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
`endif

    logic [NUM_BTN-1:0] s_sync;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan

        btn_sync u_sync (
            .clk (clk),
            .rst (rst),
            .d   (btn_in[i]),
            .q   (s_sync[i])
        );

        btn_state_t       state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             level_q, level_d;
        logic             pulse_q, pulse_d;

`ifdef BTN_AUTOREPEAT_EN
        logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
        logic             rpt_first_q, rpt_first_d;
        logic             rpt_fire;

        // Repeat timer: counts held cycles in PRESSED, freezes in RELEASE_WAIT, clears in IDLE.
        always_comb begin
            rpt_cnt_d   = rpt_cnt_q;
            rpt_first_d = rpt_first_q;
            rpt_fire    = 1'b0;
            if (state_q == IDLE) begin
                rpt_cnt_d   = '0;
                rpt_first_d = 1'b1;
            end else if (state_q == PRESSED && s_sync[i]) begin
                if (rpt_cnt_q == (rpt_first_q ? RPT_DELAY_LAST : RPT_PERIOD_LAST)) begin
                    rpt_fire    = 1'b1;
                    rpt_cnt_d   = '0;
                    rpt_first_d = 1'b0;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + RPT_ONE;
                end
            end
        end

        // Repeat timer registers.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rpt_cnt_q   <= '0;
                rpt_first_q <= 1'b1;
            end else begin
                rpt_cnt_q   <= rpt_cnt_d;
                rpt_first_q <= rpt_first_d;
            end
        end
`endif

        // Debounce FSM next state; any bounce during a wait state discards its progress.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            pulse_d = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (s_sync[i]) begin
                        state_d = PRESS_WAIT;
                        cnt_d   = CNT_ONE;
                    end else begin
                        cnt_d = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!s_sync[i]) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                        pulse_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!s_sync[i]) begin
                        state_d = RELEASE_WAIT;
                        cnt_d   = CNT_ONE;
                    end
                end
                RELEASE_WAIT: begin
                    if (s_sync[i]) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
`ifdef BTN_AUTOREPEAT_EN
            if (rpt_fire) begin
                pulse_d = 1'b1;
            end
`endif
            level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
        end

        // FSM state, counter and registered outputs.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                level_q <= 1'b0;
                pulse_q <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                level_q <= level_d;
                pulse_q <= pulse_d;
            end
        end

        assign btn_level[i] = level_q;
        assign btn_pulse[i] = pulse_q;
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed self-checking bench for btn_debounce with NUM_BTN=3,
// DEBOUNCE_CYC=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
// Expectations for the hold test follow BTN_AUTOREPEAT_EN when defined.
module tb_btn_debounce;

    logic       clk;
    logic       rst;
    logic [2:0] btn_in;
    logic [2:0] btn_level;
    logic [2:0] btn_pulse;

    int checks   = 0;
    int failures = 0;

    btn_debounce #(
        .NUM_BTN       (3),
        .DEBOUNCE_CYC  (4),
        .REPEAT_DELAY  (10),
        .REPEAT_PERIOD (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .btn_level (btn_level),
        .btn_pulse (btn_pulse)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] value);
        btn_in = value;
    endtask

    // Advance one rising edge and land on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Run n edges, counting pulses and level-high samples on one channel.
    task automatic runCycles(input int n, input int ch, output int pulses, output int level_high);
        pulses     = 0;
        level_high = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            pulses     += int'(btn_pulse[ch]);
            level_high += int'(btn_level[ch]);
        end
    endtask

    initial begin
        int  p;
        int  lh;
        int  bounce_pulses;
        logic rpt_on;
        logic [2:0] exp_pulse;

`ifdef BTN_AUTOREPEAT_EN
        rpt_on = 1'b1;
`else
        rpt_on = 1'b0;
`endif

        rst = 1'b1;
        applyStimulus(3'b000);
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_level", btn_level, 3'b000);
        checkOutput("reset_pulse", btn_pulse, 3'b000);
        rst = 1'b0;
        tick();

        // Clean press on channel 0: pulse after the 6th edge.
        applyStimulus(3'b001);
        runCycles(5, 0, p, lh);
        checkOutput("clean_early_pulse", p, 0);
        checkOutput("clean_early_level", lh, 0);
        tick();
        checkOutput("clean_pulse", btn_pulse, 3'b001);
        checkOutput("clean_level", btn_level, 3'b001);
        tick();
        checkOutput("clean_pulse_drop", btn_pulse, 3'b000);
        checkOutput("clean_level_hold", btn_level, 3'b001);

        // Two-cycle glitch, then a real release of at least four cycles.
        runCycles(2, 0, p, lh);
        checkOutput("hold_pulses", p, 0);
        applyStimulus(3'b000);
        runCycles(2, 0, p, lh);
        applyStimulus(3'b001);
        runCycles(2, 0, p, lh);
        checkOutput("glitch_level_a", lh, 2);
        applyStimulus(3'b000);
        runCycles(5, 0, p, lh);
        checkOutput("glitch_pulses", p, 0);
        checkOutput("glitch_level_b", lh, 5);
        tick();
        checkOutput("release_level", btn_level, 3'b000);
        checkOutput("release_pulse", btn_pulse, 3'b000);
        runCycles(4, 0, p, lh);
        checkOutput("release_no_pulse", p, 0);

        // Bounce on channel 1: 1,0,1,0 then stable 1.
        bounce_pulses = 0;
        applyStimulus(3'b010); runCycles(1, 1, p, lh); bounce_pulses += p;
        applyStimulus(3'b000); runCycles(1, 1, p, lh); bounce_pulses += p;
        applyStimulus(3'b010); runCycles(1, 1, p, lh); bounce_pulses += p;
        applyStimulus(3'b000); runCycles(1, 1, p, lh); bounce_pulses += p;
        applyStimulus(3'b010);
        runCycles(5, 1, p, lh);
        bounce_pulses += p;
        checkOutput("bounce_early_pulses", bounce_pulses, 0);
        tick();
        checkOutput("bounce_pulse", btn_pulse, 3'b010);
        checkOutput("bounce_level", btn_level, 3'b010);
        runCycles(6, 1, p, lh);
        checkOutput("bounce_single_pulse", p, 0);
        applyStimulus(3'b000);
        runCycles(8, 1, p, lh);
        checkOutput("bounce_release_pulses", p, 0);
        checkOutput("bounce_release_level", btn_level, 3'b000);

        // Simultaneous press on all channels.
        applyStimulus(3'b111);
        runCycles(5, 0, p, lh);
        checkOutput("simul_early_pulses", p, 0);
        tick();
        checkOutput("simul_pulse", btn_pulse, 3'b111);
        checkOutput("simul_level", btn_level, 3'b111);
        tick();
        checkOutput("simul_pulse_drop", btn_pulse, 3'b000);

        // Reset mid-hold: outputs clear at once, then one fresh press.
        rst = 1'b1;
        #1;
        checkOutput("midreset_level", btn_level, 3'b000);
        checkOutput("midreset_pulse", btn_pulse, 3'b000);
        tick();
        tick();
        rst = 1'b0;
        runCycles(5, 2, p, lh);
        checkOutput("requal_early_pulses", p, 0);
        checkOutput("requal_early_level", lh, 0);
        tick();
        checkOutput("requal_pulse", btn_pulse, 3'b111);
        checkOutput("requal_level", btn_level, 3'b111);

        // Long hold: repeat pulses at +10, +15, +20, +25, +30 only when enabled.
        for (int k = 1; k <= 30; k++) begin
            tick();
            exp_pulse = (rpt_on && k >= 10 && (k % 5) == 0) ? 3'b111 : 3'b000;
            checkOutput($sformatf("hold_k%0d", k), btn_pulse, exp_pulse);
        end
        applyStimulus(3'b000);
        runCycles(8, 0, p, lh);
        checkOutput("final_release_pulses", p, 0);
        checkOutput("final_release_level", btn_level, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
